// File: rtl/reg_dump_pkg.sv
// Shared widths, FSM encoding and frame helper for the register-file dump streamer.
package reg_dump_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RFIDX_WIDTH = 5;
  localparam int unsigned RFREG_NUM   = 32;
  localparam int unsigned FRAME_BYTES = 5;
  localparam int unsigned CNT_WIDTH   = 3;
  localparam int unsigned FRAME_WIDTH = XLEN + 8;

  typedef enum logic [1:0] {
    StIdle,
    StSel,
    StSend,
    StDone
  } state_e;

  // Header byte carries the register index; data follows LSB byte first.
  function automatic logic [FRAME_WIDTH-1:0] build_frame(input logic [XLEN-1:0]        data,
                                                         input logic [RFIDX_WIDTH-1:0] idx);
    return {data, {(8 - RFIDX_WIDTH){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/reg_dump_if.sv
// Streamer handshake bundle: start/status, register-file debug port and byte stream.
interface reg_dump_if;
  import reg_dump_pkg::*;

  logic                   start;
  logic [RFIDX_WIDTH-1:0] reg_sel;
  logic [XLEN-1:0]        reg_data;
  logic [7:0]             out_byte;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, reg_data, out_ready,
    output reg_sel, out_byte, out_valid, busy, done
  );

  modport slave (
    output start, reg_data, out_ready,
    input  reg_sel, out_byte, out_valid, busy, done
  );

endinterface

// File: rtl/reg_dump.sv
// Walks x0..x31 through the register-file debug port and streams each as a 5-byte frame.
module reg_dump
  import reg_dump_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  reg_dump_if.master bus
);

  state_e                 state_q;
  logic [RFIDX_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [FRAME_WIDTH-1:0] shift_q;
  logic                   valid_q;
  logic                   done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StSel;
            idx_q   <= '0;
          end
        end
        StSel: begin
          // Only point where reg_data is sampled; the frame is frozen from here on.
          shift_q <= build_frame(bus.reg_data, idx_q);
          cnt_q   <= '0;
          valid_q <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          if (bus.out_ready) begin
            if (cnt_q == CNT_WIDTH'(FRAME_BYTES - 1)) begin
              valid_q <= 1'b0;
              if (idx_q == RFIDX_WIDTH'(RFREG_NUM - 1)) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_q + RFIDX_WIDTH'(1);
                state_q <= StSel;
              end
            end else begin
              shift_q <= shift_q >> 8;
              cnt_q   <= cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          idx_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.reg_sel   = idx_q;
  assign bus.out_byte  = shift_q[7:0];
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: register-file model, stream monitor and per-frame comparison.
module tb_reg_dump;
  import reg_dump_pkg::*;

  logic clk;
  logic reset;

  reg_dump_if bus ();

  reg_dump u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf     [32];
  logic [31:0] exp_rf [32];
  assign bus.reg_data = (bus.reg_sel == '0) ? 32'h0 : rf[bus.reg_sel];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // out_ready driver: fixed level or coin toss, changed just after each rising edge.
  bit rand_mode   = 1'b0;
  bit ready_level = 1'b1;
  initial bus.out_ready = 1'b1;
  always begin
    @(posedge clk);
    #1;
    bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Stream monitor, sampled on the falling edge.
  logic [7:0] stream[$];
  int  done_cnt = 0;
  int  stab_err = 0;
  int  busy_err = 0;
  int  vld_err  = 0;
  bit  hold_pend = 1'b0;
  logic [7:0] hold_byte = 8'h0;
  bit  prev_done = 1'b0;
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) stream.push_back(bus.out_byte);
    if (hold_pend && bus.out_valid && bus.out_byte != hold_byte) stab_err++;
    hold_pend = bus.out_valid && !bus.out_ready;
    hold_byte = bus.out_byte;
    if (bus.done) begin
      done_cnt++;
      if (!bus.busy || bus.out_valid) busy_err++;
    end
    if (prev_done && bus.busy) busy_err++;
    prev_done = bus.done;
    if (!bus.busy && bus.out_valid) vld_err++;
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 32; i++) exp_rf[i] = (i == 0) ? 32'h0 : rf[i];
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 4000), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_stream(input string tag);
    logic [39:0] got;
    logic [39:0] exp;
    chk({tag, "_bytes"}, 64'(stream.size()), 64'd160);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    if (stream.size() == 160) begin
      for (int f = 0; f < 32; f++) begin
        got = {stream[5*f+4], stream[5*f+3], stream[5*f+2], stream[5*f+1], stream[5*f]};
        exp = {exp_rf[f], 8'(f)};
        chk($sformatf("%s_frame%0d", tag, f), 64'(got), 64'(exp));
      end
    end
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = (32'h0103_0507 * i) ^ 32'hA55A_3CC3;
    rf[1] = 32'hDEADBEEF;
    rf[5] = 32'h0BADF00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sel", 64'(bus.reg_sel), 64'd0);
    chk("rst_byte", 64'(bus.out_byte), 64'd0);
    #1 reset = 1'b0;

    // Dump A: ready high, latency and directed frame bytes.
    snapshot();
    stream.delete();
    done_cnt = 0;
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("lat_sel_busy", 64'(bus.busy), 64'd1);
    chk("lat_sel_valid", 64'(bus.out_valid), 64'd0);
    chk("lat_sel_idx", 64'(bus.reg_sel), 64'd0);
    @(negedge clk);
    chk("lat_send_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_send_byte", 64'(bus.out_byte), 64'd0);
    wait_done("dumpA");
    check_stream("dumpA");
    if (stream.size() == 160) begin
      chk("x1_bytes", 64'({stream[5], stream[6], stream[7], stream[8], stream[9]}),
          64'h01_EF_BE_AD_DE);
      chk("x0_bytes", 64'({stream[0], stream[1], stream[2], stream[3], stream[4]}), 64'h0);
    end
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_sel", 64'(bus.reg_sel), 64'd0);

    // Dump B: random backpressure plus a start pulse while busy.
    stream.delete();
    done_cnt  = 0;
    rand_mode = 1'b1;
    pulse_start();
    repeat (100) @(negedge clk);
    pulse_start();
    wait_done("dumpB");
    check_stream("dumpB");
    repeat (20) @(negedge clk);
    chk("dumpB_no_requeue", 64'(bus.busy), 64'd0);
    rand_mode = 1'b0;

    // Dump C: x5 rewritten once frame 5 is already captured.
    stream.delete();
    done_cnt = 0;
    snapshot();
    pulse_start();
    n = 0;
    while (!(bus.reg_sel == 5'd5 && bus.out_valid) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("x5_reach", 64'(n < 2000), 64'd1);
    rf[5] = 32'h12345678;
    wait_done("dumpC");
    check_stream("dumpC");

    // Dump D: new x5 value now visible.
    stream.delete();
    done_cnt = 0;
    snapshot();
    pulse_start();
    wait_done("dumpD");
    check_stream("dumpD");
    if (stream.size() == 160)
      chk("x5_new", 64'({stream[26], stream[27], stream[28], stream[29]}), 64'h78_56_34_12);

    // Reset while frame 7 byte 2 is on the bus.
    stream.delete();
    done_cnt = 0;
    pulse_start();
    n = 0;
    while (stream.size() < 38 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("f7b2_reach", 64'(n < 2000), 64'd1);
    chk("f7b2_byte", 64'(bus.out_byte), 64'(exp_rf[7][15:8]));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_sel", 64'(bus.reg_sel), 64'd0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    stream.delete();
    pulse_start();
    wait_done("dumpE");
    check_stream("dumpE");

    chk("stable_hold", 64'(stab_err), 64'd0);
    chk("busy_after_done", 64'(busy_err), 64'd0);
    chk("valid_when_idle", 64'(vld_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
